forwarding_scoreboard: RTL and testbench
========================================

Name: forwarding_scoreboard

Overview:
Parametrised operand-forwarding and load-use hazard unit for the in-order pipeline. It owns a shift pipeline of in-flight destination-register records covering every post-execute stage that can source a bypass. It produces a per-read-port forward select and a single stall request. It replaces the fixed two-stage, single-operand forwarding logic: any port count, any forwarding depth, and load-latency awareness.

Parameters:
NUM_READ_PORTS, 2, number of execute-stage source operands checked
REG_INDEX_WIDTH, 5, register index width; index 0 is hardwired zero
NUM_FWD_STAGES, 2, post-execute stages tracked (stage 0 = memory stage, last = oldest)
LOAD_DATA_STAGE, 1, first stage index whose load result is forwardable; 0 = loads forward like ALU results
SEL_WIDTH, derived clog2(NUM_FWD_STAGES+1), forward select width

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high; one clock domain
executeValid  in  1  execute stage holds a live instruction
executeWriteEnable  in  1  execute instruction writes a register
executeWriteRegisterIndex  in  REG_INDEX_WIDTH  its destination
executeIsLoad  in  1  execute instruction is a load
executeReadEnable  in  NUM_READ_PORTS  per-port operand used
executeReadRegisterIndex  in  NUM_READ_PORTS*REG_INDEX_WIDTH  packed source indices, port p at [p*W +: W]
flush  in  1  kill the execute-stage instruction this cycle
forwardSelect  out  NUM_READ_PORTS*SEL_WIDTH  packed per-port select
stall  out  1  hold execute and earlier stages
stageValid  out  NUM_FWD_STAGES  occupancy of each tracked stage (debug/verification)

Behaviour:
- Stage record = {valid, writeEnable, regIndex, isLoad}. Registered, one per stage.
- Reset: all records cleared. forwardSelect=0, stall=0, stageValid=0 in the cycle after reset is sampled high. Reset mid-operation discards all in-flight records.
- Every clock, stage s moves to s+1. The record leaving the last stage is dropped.
- Stage 0 loads the execute instruction only when executeValid && !stall && !flush. Otherwise stage 0 loads a bubble (valid=0).
- Match for port p at stage s: executeReadEnable[p] && valid && writeEnable && regIndex!=0 && regIndex==readIndex[p].
- Youngest matching stage (lowest s) wins.
- Select encoding: no match gives 0. A match at stage s gives NUM_FWD_STAGES-s. With depth 2, memory = 2'b10 and writeback = 2'b01.
- Load-use: if the winning match for any port is a load with s < LOAD_DATA_STAGE, that port's select is forced to 0 and stall=1.
- stall and forwardSelect are combinational from the records and the current execute inputs. There is no extra latency.
- executeValid=0 or flush=1 forces stall=0 and all selects=0. Flush has priority over stall.
- While stall=1, bubbles enter stage 0 and the offending load advances. Stall clears once the load reaches LOAD_DATA_STAGE: 1 cycle when LOAD_DATA_STAGE=1, LOAD_DATA_STAGE-s cycles in general.
- A load in stage ≥ LOAD_DATA_STAGE forwards like any result.
- Back-to-back writers to the same register: the younger one always wins.

Decomposition:
- Shared package forwarding_pkg holds:
  - stage-record struct;
  - SEL_WIDTH helper function;
  - FWD_SEL_REGFILE = 0 constant.
- One natural sub-module, forwarding_port_match: a combinational per-port priority matcher.
  - Takes the record array and one read index.
  - Returns select plus load-use flag.
  - Instantiated NUM_READ_PORTS times via generate.
- Top level keeps the record shift pipeline, the stall OR-reduction, and the flush/valid gating.

Test Plan:
- Reset check (defaults): reset high 2 cycles, then idle → forwardSelect=0, stall=0, stageValid=0.
- ALU chain (defaults): write x5, next cycle read x5 on port 0 → select0=2. One cycle later (no new writer) → select0=1. Then → 0.
- Priority and x0: x7 written in consecutive cycles, read on both ports → both selects=2 (youngest). A writer to x0 read back → select=0.
- Load-use (defaults): load to x3, next instruction reads x3 on port 1 → stall=1, select1=0 for 1 cycle. Stage 0 gets a bubble. Next cycle → stall=0, select1=1.
- Flush over stall: repeat the load-use case with flush=1 in the stall cycle → stall=0, selects=0, stage 0 bubble.
- Generalisation: NUM_READ_PORTS=3, NUM_FWD_STAGES=4, LOAD_DATA_STAGE=2. Load to x9, dependent read on port 2 → stall for exactly 2 cycles, then select2=2. Selects step through 2, 1, 0 as the load ages out.

Source files
------------

// File: rtl/forwarding_pkg.sv
// Shared types and helpers for the operand-forwarding / load-use hazard unit.
package forwarding_pkg;

   // Records hold indices zero-extended to this width so one struct serves every REG_INDEX_WIDTH.
   localparam int REG_INDEX_MAX_WIDTH = 8;
   localparam int FWD_SEL_REGFILE     = 0;

   typedef struct packed {
      logic                           valid;
      logic                           write_enable;
      logic [REG_INDEX_MAX_WIDTH-1:0] reg_index;
      logic                           is_load;
   } stage_rec_t;

   function automatic int sel_width(input int num_fwd_stages);
      return (num_fwd_stages < 1) ? 1 : $clog2(num_fwd_stages + 1);
   endfunction

endpackage

// File: rtl/forwarding_port_match.sv
// Per-read-port priority matcher: youngest matching in-flight writer wins;
// flags a load whose data is not yet available at the winning stage.
module forwarding_port_match
   import forwarding_pkg::*;
#(
   parameter int NUM_FWD_STAGES  = 2,
   parameter int REG_INDEX_WIDTH = 5,
   parameter int LOAD_DATA_STAGE = 1,
   parameter int SEL_WIDTH       = 2
) (
   input  stage_rec_t [NUM_FWD_STAGES-1:0] i_records,
   input  logic                            i_read_enable,
   input  logic [REG_INDEX_WIDTH-1:0]      i_read_index,
   output logic [SEL_WIDTH-1:0]            o_select,
   output logic                            o_load_use
);

   logic [SEL_WIDTH-1:0]           w_hit_sel;
   logic                           w_hit_load;
   logic [REG_INDEX_MAX_WIDTH-1:0] w_read_index;

   assign w_read_index = REG_INDEX_MAX_WIDTH'(i_read_index);

   // Walk oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      w_hit_sel  = SEL_WIDTH'(FWD_SEL_REGFILE);
      w_hit_load = 1'b0;
      for (int s = NUM_FWD_STAGES - 1; s >= 0; s--) begin
         if (i_read_enable && i_records[s].valid && i_records[s].write_enable &&
             (i_records[s].reg_index != '0) && (i_records[s].reg_index == w_read_index)) begin
            w_hit_sel  = SEL_WIDTH'(NUM_FWD_STAGES - s);
            w_hit_load = i_records[s].is_load && (s < LOAD_DATA_STAGE);
         end
      end
   end

   assign o_load_use = w_hit_load;
   assign o_select   = w_hit_load ? SEL_WIDTH'(FWD_SEL_REGFILE) : w_hit_sel;

endmodule

// File: rtl/forwarding_scoreboard.sv
// Operand-forwarding and load-use hazard unit: shift pipeline of in-flight
// destination records, per-port forward selects and a single stall request.
module forwarding_scoreboard
   import forwarding_pkg::*;
#(
   parameter  int NUM_READ_PORTS  = 2,
   parameter  int REG_INDEX_WIDTH = 5,
   parameter  int NUM_FWD_STAGES  = 2,
   parameter  int LOAD_DATA_STAGE = 1,
   localparam int SEL_WIDTH       = sel_width(NUM_FWD_STAGES)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  executeValid,
   input  logic                                  executeWriteEnable,
   input  logic [REG_INDEX_WIDTH-1:0]            executeWriteRegisterIndex,
   input  logic                                  executeIsLoad,
   input  logic [NUM_READ_PORTS-1:0]             executeReadEnable,
   input  logic [NUM_READ_PORTS*REG_INDEX_WIDTH-1:0] executeReadRegisterIndex,
   input  logic                                  flush,
   output logic [NUM_READ_PORTS*SEL_WIDTH-1:0]   forwardSelect,
   output logic                                  stall,
   output logic [NUM_FWD_STAGES-1:0]             stageValid
);

   stage_rec_t [NUM_FWD_STAGES-1:0]      r_stage;
   stage_rec_t                           w_stage0_next;
   logic                                 w_live;
   logic                                 w_accept;
   logic [NUM_READ_PORTS-1:0]            w_load_use;
   logic [NUM_READ_PORTS*SEL_WIDTH-1:0]  w_sel_raw;

   // Flush outranks any hazard: a killed or empty execute slot never stalls or forwards.
   assign w_live   = executeValid && !flush;
   assign stall    = w_live && (|w_load_use);
   assign w_accept = w_live && !(|w_load_use);

   always_comb begin
      w_stage0_next = '0;
      if (w_accept) begin
         w_stage0_next.valid        = 1'b1;
         w_stage0_next.write_enable = executeWriteEnable;
         w_stage0_next.reg_index    = REG_INDEX_MAX_WIDTH'(executeWriteRegisterIndex);
         w_stage0_next.is_load      = executeIsLoad;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stage <= '0;
      end else begin
         r_stage[0] <= w_stage0_next;
         for (int s = 1; s < NUM_FWD_STAGES; s++) begin
            r_stage[s] <= r_stage[s-1];
         end
      end
   end

   for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
      forwarding_port_match #(
         .NUM_FWD_STAGES  (NUM_FWD_STAGES),
         .REG_INDEX_WIDTH (REG_INDEX_WIDTH),
         .LOAD_DATA_STAGE (LOAD_DATA_STAGE),
         .SEL_WIDTH       (SEL_WIDTH)
      ) u_match (
         .i_records    (r_stage),
         .i_read_enable(executeReadEnable[p]),
         .i_read_index (executeReadRegisterIndex[p*REG_INDEX_WIDTH +: REG_INDEX_WIDTH]),
         .o_select     (w_sel_raw[p*SEL_WIDTH +: SEL_WIDTH]),
         .o_load_use   (w_load_use[p])
      );
   end

   assign forwardSelect = w_live ? w_sel_raw : '0;

   always_comb begin
      stageValid = '0;
      for (int s = 0; s < NUM_FWD_STAGES; s++) begin
         stageValid[s] = r_stage[s].valid;
      end
   end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard: default configuration plus a
// 3-port, 4-stage, LOAD_DATA_STAGE=2 instance.
module tb_forwarding_scoreboard;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       v1, we1, ld1, fl1;
   logic [4:0] wr1;
   logic [1:0] re1;
   logic [9:0] ri1;
   logic [3:0] fs1;
   logic       st1;
   logic [1:0] sv1;

   logic        v2, we2, ld2, fl2;
   logic [4:0]  wr2;
   logic [2:0]  re2;
   logic [14:0] ri2;
   logic [8:0]  fs2;
   logic        st2;
   logic [3:0]  sv2;

   int n_vec = 0;
   int n_err = 0;

   forwarding_scoreboard dut_def (
      .clk(clk), .reset(reset),
      .executeValid(v1), .executeWriteEnable(we1), .executeWriteRegisterIndex(wr1),
      .executeIsLoad(ld1), .executeReadEnable(re1), .executeReadRegisterIndex(ri1),
      .flush(fl1), .forwardSelect(fs1), .stall(st1), .stageValid(sv1)
   );

   forwarding_scoreboard #(
      .NUM_READ_PORTS(3), .REG_INDEX_WIDTH(5), .NUM_FWD_STAGES(4), .LOAD_DATA_STAGE(2)
   ) dut_gen (
      .clk(clk), .reset(reset),
      .executeValid(v2), .executeWriteEnable(we2), .executeWriteRegisterIndex(wr2),
      .executeIsLoad(ld2), .executeReadEnable(re2), .executeReadRegisterIndex(ri2),
      .flush(fl2), .forwardSelect(fs2), .stall(st2), .stageValid(sv2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      v1 = 0; we1 = 0; ld1 = 0; fl1 = 0; wr1 = '0; re1 = '0; ri1 = '0;
      v2 = 0; we2 = 0; ld2 = 0; fl2 = 0; wr2 = '0; re2 = '0; ri2 = '0;
   endtask

   task automatic issue1(input logic we, input logic [4:0] wr, input logic ld,
                         input logic [1:0] re, input logic [4:0] r0, input logic [4:0] r1);
      v1 = 1; fl1 = 0; we1 = we; wr1 = wr; ld1 = ld; re1 = re; ri1 = {r1, r0};
   endtask

   task automatic test_reset();
      idle_all();
      reset = 1;
      tick();
      tick();
      reset = 0;
      #1;
      n_vec++; if (fs1 !== 4'b0000) begin n_err++; $display("FAIL reset_sel: got %b expected %b", fs1, 4'b0000); end
      n_vec++; if (st1 !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected %b", st1, 1'b0); end
      n_vec++; if (sv1 !== 2'b00) begin n_err++; $display("FAIL reset_stage_valid: got %b expected %b", sv1, 2'b00); end
      n_vec++; if (sv2 !== 4'b0000) begin n_err++; $display("FAIL reset_stage_valid_gen: got %b expected %b", sv2, 4'b0000); end
      tick();
   endtask

   task automatic test_alu_chain();
      issue1(1, 5'd5, 0, 2'b00, 5'd0, 5'd0);
      #1;
      n_vec++; if (st1 !== 1'b0) begin n_err++; $display("FAIL alu_writer_stall: got %b expected %b", st1, 1'b0); end
      tick();
      issue1(0, 5'd0, 0, 2'b01, 5'd5, 5'd0);
      #1;
      n_vec++; if (fs1 !== 4'b0010) begin n_err++; $display("FAIL alu_sel_mem: got %b expected %b", fs1, 4'b0010); end
      n_vec++; if (sv1 !== 2'b01) begin n_err++; $display("FAIL alu_stage_valid: got %b expected %b", sv1, 2'b01); end
      tick();
      #1;
      n_vec++; if (fs1 !== 4'b0001) begin n_err++; $display("FAIL alu_sel_wb: got %b expected %b", fs1, 4'b0001); end
      n_vec++; if (sv1 !== 2'b11) begin n_err++; $display("FAIL alu_stage_valid2: got %b expected %b", sv1, 2'b11); end
      tick();
      #1;
      n_vec++; if (fs1 !== 4'b0000) begin n_err++; $display("FAIL alu_sel_aged_out: got %b expected %b", fs1, 4'b0000); end
      tick();
      idle_all();
      tick();
      tick();
   endtask

   task automatic test_priority();
      issue1(1, 5'd7, 0, 2'b00, 5'd0, 5'd0);
      tick();
      issue1(1, 5'd7, 0, 2'b00, 5'd0, 5'd0);
      tick();
      issue1(0, 5'd0, 0, 2'b11, 5'd7, 5'd7);
      #1;
      n_vec++; if (fs1 !== 4'b1010) begin n_err++; $display("FAIL prio_youngest: got %b expected %b", fs1, 4'b1010); end
      tick();
      idle_all();
      tick();
      tick();
      issue1(1, 5'd7, 0, 2'b00, 5'd0, 5'd0);
      tick();
      issue1(1, 5'd8, 0, 2'b00, 5'd0, 5'd0);
      tick();
      issue1(0, 5'd0, 0, 2'b11, 5'd7, 5'd8);
      #1;
      n_vec++; if (fs1 !== 4'b1001) begin n_err++; $display("FAIL prio_mixed_stages: got %b expected %b", fs1, 4'b1001); end
      tick();
      idle_all();
      tick();
      tick();
      issue1(1, 5'd0, 0, 2'b00, 5'd0, 5'd0);
      tick();
      issue1(0, 5'd0, 0, 2'b11, 5'd0, 5'd0);
      #1;
      n_vec++; if (fs1 !== 4'b0000) begin n_err++; $display("FAIL prio_x0: got %b expected %b", fs1, 4'b0000); end
      tick();
      idle_all();
      tick();
      tick();
   endtask

   task automatic test_load_use();
      issue1(1, 5'd3, 1, 2'b00, 5'd0, 5'd0);
      tick();
      issue1(1, 5'd4, 0, 2'b10, 5'd0, 5'd3);
      #1;
      n_vec++; if (st1 !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b expected %b", st1, 1'b1); end
      n_vec++; if (fs1 !== 4'b0000) begin n_err++; $display("FAIL lu_sel_forced: got %b expected %b", fs1, 4'b0000); end
      tick();
      #1;
      n_vec++; if (st1 !== 1'b0) begin n_err++; $display("FAIL lu_stall_clear: got %b expected %b", st1, 1'b0); end
      n_vec++; if (fs1 !== 4'b0100) begin n_err++; $display("FAIL lu_sel_wb: got %b expected %b", fs1, 4'b0100); end
      n_vec++; if (sv1 !== 2'b10) begin n_err++; $display("FAIL lu_bubble: got %b expected %b", sv1, 2'b10); end
      tick();
      idle_all();
      tick();
      tick();
   endtask

   task automatic test_flush_over_stall();
      issue1(1, 5'd3, 1, 2'b00, 5'd0, 5'd0);
      tick();
      issue1(1, 5'd4, 0, 2'b10, 5'd0, 5'd3);
      fl1 = 1;
      #1;
      n_vec++; if (st1 !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b expected %b", st1, 1'b0); end
      n_vec++; if (fs1 !== 4'b0000) begin n_err++; $display("FAIL flush_sel: got %b expected %b", fs1, 4'b0000); end
      tick();
      fl1 = 0;
      v1  = 0;
      #1;
      n_vec++; if (sv1 !== 2'b10) begin n_err++; $display("FAIL flush_bubble: got %b expected %b", sv1, 2'b10); end
      n_vec++; if (fs1 !== 4'b0000) begin n_err++; $display("FAIL invalid_sel_gated: got %b expected %b", fs1, 4'b0000); end
      tick();
      idle_all();
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      issue1(1, 5'd5, 0, 2'b00, 5'd0, 5'd0);
      tick();
      issue1(1, 5'd6, 0, 2'b00, 5'd0, 5'd0);
      reset = 1;
      tick();
      reset = 0;
      issue1(0, 5'd0, 0, 2'b11, 5'd5, 5'd6);
      #1;
      n_vec++; if (fs1 !== 4'b0000) begin n_err++; $display("FAIL midreset_sel: got %b expected %b", fs1, 4'b0000); end
      n_vec++; if (sv1 !== 2'b00) begin n_err++; $display("FAIL midreset_stage_valid: got %b expected %b", sv1, 2'b00); end
      tick();
      idle_all();
      tick();
      tick();
   endtask

   task automatic test_generalisation();
      v2 = 1; we2 = 1; wr2 = 5'd9; ld2 = 1; re2 = 3'b000; ri2 = '0; fl2 = 0;
      tick();
      we2 = 0; wr2 = 5'd0; ld2 = 0; re2 = 3'b100; ri2 = {5'd9, 5'd0, 5'd0};
      #1;
      n_vec++; if (st2 !== 1'b1) begin n_err++; $display("FAIL gen_stall_c1: got %b expected %b", st2, 1'b1); end
      n_vec++; if (fs2 !== 9'd0) begin n_err++; $display("FAIL gen_sel_c1: got %b expected %b", fs2, 9'd0); end
      tick();
      #1;
      n_vec++; if (st2 !== 1'b1) begin n_err++; $display("FAIL gen_stall_c2: got %b expected %b", st2, 1'b1); end
      n_vec++; if (sv2 !== 4'b0010) begin n_err++; $display("FAIL gen_stage_valid_c2: got %b expected %b", sv2, 4'b0010); end
      tick();
      #1;
      n_vec++; if (st2 !== 1'b0) begin n_err++; $display("FAIL gen_stall_c3: got %b expected %b", st2, 1'b0); end
      n_vec++; if (fs2 !== 9'b010_000_000) begin n_err++; $display("FAIL gen_sel_2: got %b expected %b", fs2, 9'b010_000_000); end
      n_vec++; if (sv2 !== 4'b0100) begin n_err++; $display("FAIL gen_stage_valid_c3: got %b expected %b", sv2, 4'b0100); end
      tick();
      #1;
      n_vec++; if (fs2 !== 9'b001_000_000) begin n_err++; $display("FAIL gen_sel_1: got %b expected %b", fs2, 9'b001_000_000); end
      tick();
      #1;
      n_vec++; if (fs2 !== 9'd0) begin n_err++; $display("FAIL gen_sel_0: got %b expected %b", fs2, 9'd0); end
      n_vec++; if (st2 !== 1'b0) begin n_err++; $display("FAIL gen_stall_end: got %b expected %b", st2, 1'b0); end
      tick();
      idle_all();
      tick();
   endtask

   initial begin
      reset = 1;
      idle_all();
      test_reset();
      test_alu_chain();
      test_priority();
      test_load_use();
      test_flush_over_stall();
      test_reset_mid();
      test_generalisation();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
